// File: rtl/sample_output_multichannel.sv
// sample_output_multichannel: captures a frame of signed samples, mixes, clamps and offsets
// them to unsigned DAC codes, then hands one 24-bit SPI word per channel to the serialiser.
module sample_output_multichannel #(
    parameter int         NUM_CHANNELS = 2,
    parameter int         IN_WIDTH     = 32,
    parameter int         SHIFT        = 2,
    parameter int         DAC_BITS     = 16,
    parameter logic [7:0] CMD_BASE     = 8'h30
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    input  logic                             i_Start,
    input  logic [NUM_CHANNELS*IN_WIDTH-1:0] i_Samples,
    input  logic [1:0]                       i_Mode,
    input  logic                             i_DAC_Ready,
    output logic [23:0]                      o_DAC_Data,
    output logic                             o_DAC_Send,
    output logic                             o_Busy,
    output logic                             o_Done,
    output logic                             o_Overrun,
    output logic [7:0]                       o_Overrun_Count
);
    localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam logic signed [31:0] OFF = (32'sd1 <<< (DAC_BITS - 1)) - 32'sd1;

    typedef enum logic [2:0] {IDLE, MIX, CLAMP, OFFSET, SEND, WAIT_LOW, WAIT_HIGH} state_t;

    state_t             state, state_next;
    logic [IW-1:0]      idx;
    logic [1:0]         mode;
    logic signed [31:0] val [NUM_CHANNELS];
    logic signed [31:0] cap [NUM_CHANNELS];
    logic signed [31:0] sum;
    logic               last, accept, reject;
    logic [15:0]        field;

    always_comb begin
        sum = '0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            cap[n] = 32'($signed(i_Samples[n*IN_WIDTH +: IN_WIDTH]) >>> SHIFT);
            sum = sum + val[n];
        end
    end

    // A start coinciding with the done pulse is rejected so frames never abut.
    assign accept = state == IDLE && i_Start && i_DAC_Ready && !o_Done;
    assign reject = i_Start && !accept;
    assign last   = idx == IW'(NUM_CHANNELS - 1);
    assign field  = 16'(val[idx][DAC_BITS-1:0]) << (16 - DAC_BITS);

    always_ff @(posedge i_Clock) state <= i_Reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = accept ? MIX : IDLE;
            MIX:       state_next = CLAMP;
            CLAMP:     state_next = OFFSET;
            OFFSET:    state_next = SEND;
            SEND:      state_next = WAIT_LOW;
            WAIT_LOW:  state_next = i_DAC_Ready ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: state_next = !i_DAC_Ready ? WAIT_HIGH : last ? IDLE : SEND;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int n = 0; n < NUM_CHANNELS; n++) val[n] <= '0;
            idx             <= '0;
            mode            <= '0;
            o_DAC_Data      <= '0;
            o_DAC_Send      <= 1'b0;
            o_Busy          <= 1'b0;
            o_Done          <= 1'b0;
            o_Overrun       <= 1'b0;
            o_Overrun_Count <= '0;
        end else begin
            o_Busy    <= state_next != IDLE;
            o_Done    <= state == WAIT_HIGH && i_DAC_Ready && last;
            o_Overrun <= reject;
            if (reject && o_Overrun_Count != 8'hFF) o_Overrun_Count <= o_Overrun_Count + 8'd1;
            if (accept) mode <= i_Mode;
            for (int n = 0; n < NUM_CHANNELS; n++)
                val[n] <= accept ? cap[n] :
                          state == MIX ? (mode == 2'b01 ? sum : mode == 2'b10 ? '0 : val[n]) :
                          state == CLAMP ? (val[n] > OFF ? OFF : val[n] < -OFF ? -OFF : val[n]) :
                          state == OFFSET ? val[n] + OFF : val[n];
            if (state == SEND) begin
                o_DAC_Data <= {CMD_BASE + 8'(idx) + 8'd1, field};
                o_DAC_Send <= 1'b1;
            end
            if (state == WAIT_LOW && !i_DAC_Ready) o_DAC_Send <= 1'b0;
            if (state == WAIT_HIGH && i_DAC_Ready) idx <= last ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_sample_output_multichannel.sv
// tb_sample_output_multichannel: directed frames on a 2-channel/16-bit and a 4-channel/12-bit
// instance, with a serialiser model and a word scoreboard per instance.
module tb_sample_output_multichannel;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0;

    logic         start_a = 1'b0, rdy_ma = 1'b1, kill_a = 1'b0, rdy_a;
    logic [63:0]  samp_a = '0;
    logic [1:0]   mode_a = '0;
    logic [23:0]  data_a;
    logic         send_a, busy_a, done_a, ovr_a;
    logic [7:0]   ovc_a;
    assign rdy_a = rdy_ma && !kill_a;

    logic         start_b = 1'b0, rdy_b = 1'b1;
    logic [127:0] samp_b = '0;
    logic [1:0]   mode_b = '0;
    logic [23:0]  data_b;
    logic         send_b, busy_b, done_b, ovr_b;
    logic [7:0]   ovc_b;

    sample_output_multichannel dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start_a), .i_Samples(samp_a), .i_Mode(mode_a),
        .i_DAC_Ready(rdy_a), .o_DAC_Data(data_a), .o_DAC_Send(send_a), .o_Busy(busy_a),
        .o_Done(done_a), .o_Overrun(ovr_a), .o_Overrun_Count(ovc_a));

    sample_output_multichannel #(.NUM_CHANNELS(4), .DAC_BITS(12)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start_b), .i_Samples(samp_b), .i_Mode(mode_b),
        .i_DAC_Ready(rdy_b), .o_DAC_Data(data_b), .o_DAC_Send(send_b), .o_Busy(busy_b),
        .o_Done(done_b), .o_Overrun(ovr_b), .o_Overrun_Count(ovc_b));

    logic [23:0] q_a[$], q_b[$];
    int words_a = 0, done_cnt_a = 0, ovr_cnt_a = 0, words_b = 0, done_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] exp_a(input int ch, input logic [31:0] s);
        int v;
        v = int'($signed(s)) >>> 2;
        v = v > 32767 ? 32767 : v < -32767 ? -32767 : v;
        return {8'h31 + 8'(ch), 16'(v + 32767)};
    endfunction

    // Serialiser models: accept a word, go busy a little later, come back after a few cycles.
    initial forever begin
        @(negedge clk);
        if (send_a && rdy_ma) begin
            repeat (2) @(negedge clk);
            rdy_ma = 1'b0;
            repeat (3) @(negedge clk);
            rdy_ma = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (send_b && rdy_b) begin
            repeat (1) @(negedge clk);
            rdy_b = 1'b0;
            repeat (2) @(negedge clk);
            rdy_b = 1'b1;
        end
    end

    initial begin : mon_a
        logic p;
        logic [23:0] e;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (send_a && !p) begin
                e = 'x;
                if (q_a.size() > 0) e = q_a.pop_front();
                words_a++;
                chk("word_a", data_a, e);
            end
            if (done_a) done_cnt_a++;
            if (ovr_a) ovr_cnt_a++;
            p = send_a;
        end
    end

    initial begin : mon_b
        logic p;
        logic [23:0] e;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (send_b && !p) begin
                e = 'x;
                if (q_b.size() > 0) e = q_b.pop_front();
                words_b++;
                chk("word_b", data_b, e);
            end
            if (done_b) done_cnt_b++;
            p = send_b;
        end
    end

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_a_seen", 32'(done_a), 1);
        @(negedge clk);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!done_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_b_seen", 32'(done_b), 1);
        @(negedge clk);
    endtask

    task automatic run_a(input logic [31:0] s0, s1, input logic [1:0] m, input logic [23:0] e0, e1);
        start_a = 1'b1; samp_a = {s1, s0}; mode_a = m;
        q_a.push_back(e0); q_a.push_back(e1);
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a();
    endtask

    initial begin
        int st, n, d0, o0, w;
        repeat (3) @(negedge clk);
        chk("rst_data", data_a, 0);
        chk("rst_send", 32'(send_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_ovr", 32'(ovr_a), 0);
        chk("rst_ovc", ovc_a, 0);
        chk("rst_data_b", data_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: direct, high clamp, latency and single done pulse
        d0 = done_cnt_a;
        start_a = 1'b1; samp_a = {32'd160000, 32'd0}; mode_a = 2'b00;
        q_a.push_back(24'h317FFF); q_a.push_back(24'h32FFFE);
        @(negedge clk);
        start_a = 1'b0; st = cyc;
        chk("t1_busy", 32'(busy_a), 1);
        n = 0;
        while (!send_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", cyc - st, 4);
        wait_done_a();
        chk("t1_done_once", done_cnt_a - d0, 1);
        chk("t1_idle", 32'(busy_a), 0);

        // T2: low clamp and small values around zero
        run_a(-32'sd200000, 32'd0, 2'b00, 24'h310000, 24'h327FFF);
        run_a(-32'sd4, 32'd0, 2'b00, 24'h317FFE, 24'h327FFF);
        run_a(32'd4, 32'd0, 2'b00, 24'h318000, 24'h327FFF);

        // T3: sum mode
        run_a(32'd4000, 32'd8000, 2'b01, 24'h318BB7, 24'h328BB7);

        // T4: 12-bit, 4 channels, mute
        start_b = 1'b1; samp_b = {$urandom, $urandom, $urandom, $urandom}; mode_b = 2'b10;
        q_b.push_back(24'h317FF0); q_b.push_back(24'h327FF0);
        q_b.push_back(24'h337FF0); q_b.push_back(24'h347FF0);
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b();
        chk("t4_words_b", words_b, 4);

        // direct mode (00 and 11) with random samples
        for (int i = 0; i < 4; i++) begin
            int s0 = int'($urandom_range(0, 300000)) - 150000;
            int s1 = int'($urandom_range(0, 300000)) - 150000;
            run_a(s0, s1, i[0] ? 2'b11 : 2'b00, exp_a(0, s0), exp_a(1, s1));
        end

        // T5: three starts during a frame are rejected
        o0 = ovr_cnt_a;
        start_a = 1'b1; samp_a = {32'd400, 32'd800}; mode_a = 2'b00;
        q_a.push_back(exp_a(0, 32'd800)); q_a.push_back(exp_a(1, 32'd400));
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (k == 0 ? 2 : 3) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_done_a();
        chk("t5_ovr_pulses", ovr_cnt_a - o0, 3);
        chk("t5_ovc", ovc_a, 3);

        // start in the done cycle is an overrun; the next cycle is accepted
        start_a = 1'b1; samp_a = {32'd0, 32'd0}; mode_a = 2'b00;
        q_a.push_back(24'h317FFF); q_a.push_back(24'h327FFF);
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("dc_done_seen", 32'(done_a), 1);
        start_a = 1'b1;
        @(negedge clk);
        chk("dc_ovr", 32'(ovr_a), 1);
        chk("dc_not_busy", 32'(busy_a), 0);
        q_a.push_back(24'h317FFF); q_a.push_back(24'h327FFF);
        @(negedge clk);
        start_a = 1'b0;
        chk("dc_accept_busy", 32'(busy_a), 1);
        chk("dc_accept_no_ovr", 32'(ovr_a), 0);
        wait_done_a();
        chk("dc_ovc", ovc_a, 4);

        // T5: saturation with ready held low
        o0 = ovr_cnt_a;
        kill_a = 1'b1; start_a = 1'b1;
        repeat (300) @(negedge clk);
        start_a = 1'b0; kill_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_ovr_pulses", ovr_cnt_a - o0, 300);
        chk("sat_ovc", ovc_a, 255);
        chk("sat_idle", 32'(busy_a), 0);

        // T6: reset in WAIT_HIGH of ch0 aborts the frame
        start_a = 1'b1; samp_a = {32'd0, 32'd0}; mode_a = 2'b00;
        q_a.push_back(24'h317FFF); q_a.push_back(24'h327FFF);
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!send_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_send_high", 32'(send_a), 1);
        while (send_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_send_low", 32'(send_a), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_send", 32'(send_a), 0);
        chk("t6_rst_data", data_a, 0);
        chk("t6_rst_busy", 32'(busy_a), 0);
        chk("t6_rst_ovc", ovc_a, 0);
        q_a.delete();
        w = words_a;
        repeat (15) @(negedge clk);
        chk("t6_no_ch1", words_a, w);
        run_a(32'd0, 32'd160000, 2'b00, 24'h317FFF, 24'h32FFFE);

        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
